// File: rtl/axis_strip_pkg.sv
// Shared types and byte-mask helpers for the AXI-Stream header stripper.
package axis_strip_pkg;

    typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_e;

    // Helpers work on masks up to MAXB bytes; callers size-cast to their lane count.
    localparam int MAXB = 64;
    localparam logic [MAXB-1:0] HDR_NONE = '0;

    function automatic logic [7:0] popcount(input logic [MAXB-1:0] mask);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < MAXB; i++) n = n + {7'd0, mask[i]};
        return n;
    endfunction

    function automatic logic [MAXB-1:0] cnt2keep_msb(input logic [7:0] n, input logic [7:0] nbytes);
        logic [MAXB-1:0] k;
        k = '0;
        for (int i = 0; i < MAXB; i++)
            if ((i < int'(nbytes)) && (i >= int'(nbytes) - int'(n))) k[i] = 1'b1;
        return k;
    endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Residue register plus the shift/merge of the held P bytes with the top H bytes of the next beat.
module axis_byte_realign
    import axis_strip_pkg::*;
#(
    parameter int DATA_WD     = 32,
    parameter int BYTE_CNT_WD = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [BYTE_CNT_WD:0]   hdr_cnt_i,
    input  logic [DATA_WD-1:0]     beat_i,
    output logic [DATA_WD-1:0]     merged_o,
    output logic [DATA_WD-1:0]     tail_o
);
    localparam int DATA_BYTE_WD = DATA_WD / 8;

    logic [DATA_WD-1:0]      res_q;
    logic [BYTE_CNT_WD:0]    pay_cnt;
    logic [BYTE_CNT_WD+3:0]  hdr_sh;
    logic [BYTE_CNT_WD+3:0]  pay_sh;

    assign pay_cnt  = (BYTE_CNT_WD+1)'(DATA_BYTE_WD) - hdr_cnt_i;
    assign hdr_sh   = {hdr_cnt_i, 3'b000};
    assign pay_sh   = {pay_cnt, 3'b000};
    // Low P bytes of the held beat move up to the MSB lanes.
    assign tail_o   = res_q << hdr_sh;
    assign merged_o = tail_o | (beat_i >> pay_sh);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       res_q <= '0;
        else if (load_i) res_q <= beat_i;
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips an H-byte header (H = popcount(keep_strip)) off an AXI-Stream packet and repacks the payload from lane MSB.
// Optional AXIS_STRIP_ERR_EN adds err_short, a one-cycle pulse on short packets.
//   state | meaning
//   IDLE  | waiting for a header-length descriptor
//   FIRST | waiting for the first beat (header + first residue)
//   BODY  | merging residue with each following beat
//   FLUSH | emitting the leftover residue bytes as the last beat
module axi_stream_strip_header
    import axis_strip_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef AXIS_STRIP_ERR_EN
    output logic                    err_short,
`endif
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_strip,
    input  logic [DATA_BYTE_WD-1:0] keep_strip,
    output logic                    ready_strip,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr
);
    localparam logic [BYTE_CNT_WD:0]    NB       = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);
    localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;

    function automatic logic [DATA_WD-1:0] mask_bytes(input logic [DATA_WD-1:0] d,
                                                      input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] r;
        r = d;
        for (int b = 0; b < DATA_BYTE_WD; b++) if (!k[b]) r[8*b +: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] keep_msb(input logic [BYTE_CNT_WD:0] n);
        return DATA_BYTE_WD'(cnt2keep_msb(8'(n), 8'(DATA_BYTE_WD)));
    endfunction

    state_e                  state_q, state_d;
    logic [BYTE_CNT_WD:0]    h_q, h_d, flush_q, flush_d;
    logic [BYTE_CNT_WD:0]    k_in, h_new, p_cnt;
    logic                    valid_out_q, valid_out_d, last_out_q, last_out_d;
    logic                    valid_hdr_q, valid_hdr_d, ready_strip_q, ready_strip_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d, data_hdr_q, data_hdr_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d, keep_hdr_q, keep_hdr_d, hdr_keep_new;
    logic [DATA_WD-1:0]      merged, tail;
    logic                    res_load, in_fire, strip_fire, out_free, hdr_free;
`ifdef AXIS_STRIP_ERR_EN
    logic                    err_q, err_d;
    assign err_short = err_q;
`endif

    assign k_in         = (BYTE_CNT_WD+1)'(popcount(MAXB'(keep_in)));
    assign h_new        = (BYTE_CNT_WD+1)'(popcount(MAXB'(keep_strip)));
    assign p_cnt        = NB - h_q;
    assign hdr_keep_new = keep_in >> p_cnt;
    assign out_free     = !valid_out_q || ready_out;
    assign hdr_free     = !valid_hdr_q || ready_hdr;
    assign in_fire      = valid_in && ready_in;
    assign strip_fire   = valid_strip && ready_strip_q;

    always_comb begin
        case (state_q)
            FIRST:   ready_in = out_free && hdr_free;
            BODY:    ready_in = out_free;
            default: ready_in = 1'b0;
        endcase
    end

    axis_byte_realign #(.DATA_WD(DATA_WD), .BYTE_CNT_WD(BYTE_CNT_WD)) u_realign (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (res_load),
        .hdr_cnt_i (h_q),
        .beat_i    (data_in),
        .merged_o  (merged),
        .tail_o    (tail)
    );

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        flush_d     = flush_q;
        valid_out_d = valid_out_q && !ready_out;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        valid_hdr_d = valid_hdr_q && !ready_hdr;
        data_hdr_d  = data_hdr_q;
        keep_hdr_d  = keep_hdr_q;
        res_load    = 1'b0;
`ifdef AXIS_STRIP_ERR_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: if (strip_fire) begin
                h_d     = h_new;
                state_d = FIRST;
            end
            FIRST: if (in_fire) begin
                if (h_q == '0) begin
                    valid_out_d = 1'b1;
                    data_out_d  = mask_bytes(data_in, keep_in);
                    keep_out_d  = keep_in;
                    last_out_d  = last_in;
                    state_d     = last_in ? IDLE : BODY;
                end else begin
                    valid_hdr_d = 1'b1;
                    keep_hdr_d  = hdr_keep_new;
                    data_hdr_d  = mask_bytes(data_in >> {p_cnt, 3'b000}, hdr_keep_new);
                    res_load    = 1'b1;
`ifdef AXIS_STRIP_ERR_EN
                    err_d = (last_in && (k_in <= h_q)) || ((keep_in != KEEP_ALL) && (k_in < h_q));
`endif
                    if (last_in && (k_in <= h_q)) begin
                        state_d = IDLE;
                    end else if (last_in) begin
                        flush_d = k_in - h_q;
                        state_d = FLUSH;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            BODY: if (in_fire) begin
                valid_out_d = 1'b1;
                if (h_q == '0) begin
                    data_out_d = mask_bytes(data_in, keep_in);
                    keep_out_d = keep_in;
                    last_out_d = last_in;
                    if (last_in) state_d = IDLE;
                end else if (last_in && (k_in <= h_q)) begin
                    keep_out_d = keep_msb(p_cnt + k_in);
                    data_out_d = mask_bytes(merged, keep_msb(p_cnt + k_in));
                    last_out_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    data_out_d = merged;
                    keep_out_d = KEEP_ALL;
                    last_out_d = 1'b0;
                    res_load   = 1'b1;
                    if (last_in) begin
                        flush_d = k_in - h_q;
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: if (out_free) begin
                valid_out_d = 1'b1;
                keep_out_d  = keep_msb(flush_q);
                data_out_d  = mask_bytes(tail, keep_msb(flush_q));
                last_out_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_strip_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            h_q           <= '0;
            flush_q       <= '0;
            valid_out_q   <= 1'b0;
            data_out_q    <= '0;
            keep_out_q    <= '0;
            last_out_q    <= 1'b0;
            valid_hdr_q   <= 1'b0;
            data_hdr_q    <= '0;
            keep_hdr_q    <= DATA_BYTE_WD'(HDR_NONE);
            ready_strip_q <= 1'b0;
`ifdef AXIS_STRIP_ERR_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            flush_q       <= flush_d;
            valid_out_q   <= valid_out_d;
            data_out_q    <= data_out_d;
            keep_out_q    <= keep_out_d;
            last_out_q    <= last_out_d;
            valid_hdr_q   <= valid_hdr_d;
            data_hdr_q    <= data_hdr_d;
            keep_hdr_q    <= keep_hdr_d;
            ready_strip_q <= ready_strip_d;
`ifdef AXIS_STRIP_ERR_EN
            err_q         <= err_d;
`endif
        end
    end

    assign valid_out   = valid_out_q;
    assign data_out    = data_out_q;
    assign keep_out    = keep_out_q;
    assign last_out    = last_out_q;
    assign valid_hdr   = valid_hdr_q;
    assign data_hdr    = data_hdr_q;
    assign keep_hdr    = keep_hdr_q;
    assign ready_strip = ready_strip_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench: packets are built as header ++ payload bytes, and the expected header and payload beats are derived from the byte lists.
module tb_axi_stream_strip_header;
    localparam int NB  = 4;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, last_in, ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_strip, ready_strip;
    logic [3:0]  keep_strip;
    logic        valid_out, last_out, ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_hdr, ready_hdr;
    logic [31:0] data_hdr;
    logic [3:0]  keep_hdr;
`ifdef AXIS_STRIP_ERR_EN
    logic        err_short;
    int          err_seen = 0;
`endif

    typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
    beat_t      exp_out[$];
    beat_t      exp_hdr[$];
    logic [7:0] pkt[$];
    int checks = 0, errors = 0, exp_short = 0;
    int rdy_mode = 0, hdr_block = 0;

    always #5 clk = ~clk;

    axi_stream_strip_header dut (
        .clk(clk), .rst(rst),
`ifdef AXIS_STRIP_ERR_EN
        .err_short(err_short),
`endif
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_strip(valid_strip), .keep_strip(keep_strip), .ready_strip(ready_strip),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid_out"}, 32'(valid_out), 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_keep_out"}, 32'(keep_out), 0);
        chk({tag, "_last_out"}, 32'(last_out), 0);
        chk({tag, "_ready_in"}, 32'(ready_in), 0);
        chk({tag, "_valid_hdr"}, 32'(valid_hdr), 0);
        chk({tag, "_data_hdr"}, data_hdr, 0);
        chk({tag, "_keep_hdr"}, 32'(keep_hdr), 0);
        chk({tag, "_ready_strip"}, 32'(ready_strip), 0);
`ifdef AXIS_STRIP_ERR_EN
        chk({tag, "_err_short"}, 32'(err_short), 0);
`endif
    endtask

    // Reference: header = first min(L,H) bytes placed from lane H-1 downward; payload = remaining bytes packed MSB-first.
    task automatic push_expected(input int h);
        int    len;
        beat_t b;
        len = pkt.size();
        if (h > 0) begin
            b.d = '0; b.k = '0; b.l = 1'b0;
            for (int i = 0; i < h && i < len; i++) begin
                b.d[8*(h-1-i) +: 8] = pkt[i];
                b.k[h-1-i] = 1'b1;
            end
            exp_hdr.push_back(b);
            if (len <= h) exp_short++;
        end
        for (int s = h; s < len; s += NB) begin
            b.d = '0; b.k = '0;
            for (int j = 0; j < NB && s + j < len; j++) begin
                b.d[8*(NB-1-j) +: 8] = pkt[s+j];
                b.k[NB-1-j] = 1'b1;
            end
            b.l = (s + NB >= len);
            exp_out.push_back(b);
        end
    endtask

    // Called at posedge+1; returns at posedge+1. max_beats < 0 sends the whole packet.
    task automatic send_packet(input int h, input int gap_pct, input int max_beats);
        int len, nbeats, t;
        len    = pkt.size();
        nbeats = (len + NB - 1) / NB;
        push_expected(h);
        valid_strip = 1'b1;
        keep_strip  = 4'((1 << h) - 1);
        t = 0;
        do begin @(negedge clk); t++; end while (!ready_strip && t < TMO);
        if (!ready_strip) chk("descriptor_timeout", 0, 1);
        @(posedge clk); #1;
        valid_strip = 1'b0;
        keep_strip  = '0;
        for (int bi = 0; bi < nbeats && (max_beats < 0 || bi < max_beats); bi++) begin
            logic [31:0] d;
            logic [3:0]  k;
            d = '0; k = '0;
            for (int j = 0; j < NB; j++)
                if (bi*NB + j < len) begin
                    d[8*(NB-1-j) +: 8] = pkt[bi*NB + j];
                    k[NB-1-j] = 1'b1;
                end
            if ($urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            valid_in = 1'b1; data_in = d; keep_in = k; last_in = (bi == nbeats - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (bi == 0 && valid_hdr && !ready_hdr) chk("ready_in_while_hdr_pending", 32'(ready_in), 0);
                if (ready_in || t >= TMO) break;
                t++;
            end
            if (!ready_in) chk("beat_accept_timeout", 0, 1);
            @(posedge clk); #1;
            valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
            if (h == 0 && bi == 0) begin
                chk("h0_zero_latency_valid", 32'(valid_out), 1);
                chk("h0_zero_latency_data", data_out, d);
            end
        end
    endtask

    task automatic make_pkt(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    endtask

    initial begin
        ready_out = 1'b0; ready_hdr = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: begin ready_out = 1'b1; ready_hdr = 1'b1; end
                1: begin
                    ready_out = ($urandom_range(0, 6) != 0);
                    if (hdr_block > 0) begin ready_hdr = 1'b0; hdr_block--; end
                    else if ($urandom_range(0, 5) == 0) begin ready_hdr = 1'b0; hdr_block = 4; end
                    else ready_hdr = 1'b1;
                end
                default: begin
                    ready_out = ($urandom_range(0, 1) == 1);
                    ready_hdr = ($urandom_range(0, 1) == 1);
                end
            endcase
        end
    end

    // Monitor: a transfer happens at the next posedge when valid && ready are seen at negedge.
    beat_t       e;
    logic        pv_out = 1'b0, pv_hdr = 1'b0;
    logic [31:0] pd_out, pd_hdr;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            pv_out = 1'b0; pv_hdr = 1'b0;
        end else begin
            if (pv_out) begin
                checks++;
                if (!valid_out || data_out !== pd_out) begin
                    errors++;
                    $display("FAIL out_hold: valid %b data %h, required valid 1 data %h", valid_out, data_out, pd_out);
                end
            end
            if (pv_hdr) begin
                checks++;
                if (!valid_hdr || data_hdr !== pd_hdr) begin
                    errors++;
                    $display("FAIL hdr_hold: valid %b data %h, required valid 1 data %h", valid_hdr, data_hdr, pd_hdr);
                end
            end
            if (valid_out && ready_out) begin
                checks++;
                if (exp_out.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: data %h keep %b last %b", data_out, keep_out, last_out);
                end else begin
                    e = exp_out.pop_front();
                    if (data_out !== e.d || keep_out !== e.k || last_out !== e.l) begin
                        errors++;
                        $display("FAIL payload: got %h/%b/%b expected %h/%b/%b", data_out, keep_out, last_out, e.d, e.k, e.l);
                    end
                end
            end
            if (valid_hdr && ready_hdr) begin
                checks++;
                if (exp_hdr.size() == 0) begin
                    errors++;
                    $display("FAIL hdr_unexpected: data %h keep %b", data_hdr, keep_hdr);
                end else begin
                    e = exp_hdr.pop_front();
                    if (data_hdr !== e.d || keep_hdr !== e.k) begin
                        errors++;
                        $display("FAIL header: got %h/%b expected %h/%b", data_hdr, keep_hdr, e.d, e.k);
                    end
                end
            end
`ifdef AXIS_STRIP_ERR_EN
            if (err_short) err_seen++;
`endif
            pv_out = valid_out && !ready_out; pd_out = data_out;
            pv_hdr = valid_hdr && !ready_hdr; pd_hdr = data_hdr;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_strip = 1'b0; keep_strip = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed: H=3 12-byte packet
        pkt.delete();
        for (int i = 0; i < 12; i++) pkt.push_back(8'(i));
        send_packet(3, 0, -1);
        // H=0 pass-through, H=4 short, H=1 with last K=1 and K=3
        make_pkt(8);  send_packet(0, 0, -1);
        make_pkt(2);  send_packet(4, 0, -1);
        make_pkt(9);  send_packet(1, 0, -1);
        make_pkt(11); send_packet(1, 0, -1);

        rdy_mode = 1;
        for (int n = 0; n < 30; n++) begin
            make_pkt($urandom_range(1, 20));
            send_packet($urandom_range(0, 4), 20, -1);
        end

        // Reset in the middle of a packet body
        rdy_mode = 0;
        make_pkt(24);
        send_packet(2, 0, 3);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid_reset");
        exp_out.delete();
        exp_hdr.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        make_pkt(10); send_packet(3, 0, -1);

        rdy_mode = 2;
        for (int n = 0; n < 25; n++) begin
            make_pkt($urandom_range(1, 16));
            send_packet($urandom_range(0, 4), 30, -1);
        end

        rdy_mode = 0;
        t = 0;
        while ((exp_out.size() != 0 || exp_hdr.size() != 0) && t < 1000) begin @(posedge clk); t++; end
        repeat (5) @(posedge clk);
        #1;
        chk("payload_queue_drained", 32'(exp_out.size()), 0);
        chk("header_queue_drained", 32'(exp_hdr.size()), 0);
`ifdef AXIS_STRIP_ERR_EN
        chk("err_short_count", 32'(err_seen), 32'(exp_short));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
